// File: rtl/uex_mem_arb.sv
// uex_mem_arb: round-robin arbiter that funnels N_REQ requesters onto a
// single memory port. Only one transaction is in flight at a time
// (IDLE -> ISSUE -> WAIT).
// Optional feature macro: UEX_MEM_ARB_TIMEOUT_EN. When it is defined, a
// response that never arrives ends after TIMEOUT WAIT cycles with an error
// response.
module uex_mem_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*32-1:0]        req_addr,
    input  logic [N_REQ*32-1:0]        req_wdata,
    input  logic [N_REQ-1:0]           req_write,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic                       mem_write,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_rdata,
    input  logic                       mem_rsp_err,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   winner;
    logic            found;
    logic            accept;
    logic            done;

    // An empty named block that references TIMEOUT, so the parameter is
    // used in every build. It elaborates only if TIMEOUT is out of range.
    if (TIMEOUT < 1) begin : g_timeout_range
    end

`ifdef UEX_MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   tmo_cnt;
    logic            tmo;
`endif

    // Round-robin search: start at the requester after last_grant and wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!found && req_valid[(int'(last_grant) + i) % N_REQ]) begin
                winner = GW'((int'(last_grant) + i) % N_REQ);
                found  = 1'b1;
            end
        end
    end

    // Next-state logic and the single-cycle accept strobe.
    always_comb begin
        state_nx  = state;
        req_ready = '0;
        accept    = 1'b0;
        done      = 1'b0;
`ifdef UEX_MEM_ARB_TIMEOUT_EN
        tmo       = 1'b0;
`endif
        case (state)
            IDLE: begin
                // reset_n is in this term so no accept is seen while reset is held.
                if (found && reset_n) begin
                    req_ready[winner] = 1'b1;
                    accept            = 1'b1;
                    state_nx          = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
`ifdef UEX_MEM_ARB_TIMEOUT_EN
                // The counter is 0 in the first WAIT cycle. A value of
                // TIMEOUT-1 therefore marks the TIMEOUT-th WAIT cycle.
                else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req_valid = (state == ISSUE);
    assign busy          = (state != IDLE);

    // State register plus the latched request and grant bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(N_REQ - 1);
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                grant_id  <= winner;
                mem_addr  <= req_addr[int'(winner)*32 +: 32];
                mem_wdata <= req_wdata[int'(winner)*32 +: 32];
                mem_write <= req_write[winner];
            end
`ifdef UEX_MEM_ARB_TIMEOUT_EN
            if (done || tmo) last_grant <= grant_id;
`else
            if (done) last_grant <= grant_id;
`endif
        end
    end

    // Registered response. Data holds its value between strobes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (done) begin
                rsp_valid[grant_id] <= 1'b1;
                rsp_rdata           <= mem_rsp_rdata;
                rsp_err             <= mem_rsp_err;
            end
`ifdef UEX_MEM_ARB_TIMEOUT_EN
            else if (tmo) begin
                rsp_valid[grant_id] <= 1'b1;
                rsp_rdata           <= '0;
                rsp_err             <= 1'b1;
            end
`endif
        end
    end

`ifdef UEX_MEM_ARB_TIMEOUT_EN
    // WAIT-cycle counter. It clears on the ISSUE->WAIT handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE && mem_req_ready) begin
            tmo_cnt <= '0;
        end else if (state == WAIT && tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uex_mem_arb.sv
// Scoreboard bench for uex_mem_arb. The stimulus pushes the expected grants,
// memory requests and responses. Monitors pop and compare those whenever the
// DUT strobes. A small memory model answers one cycle after each handshake.
module tb_uex_mem_arb;
    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_addr = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    req_write = '0;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [31:0]     mem_addr, mem_wdata;
    logic            mem_write;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_rdata = '0;
    logic            mem_rsp_err = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;

    uex_mem_arb #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .mem_rsp_err(mem_rsp_err), .busy(busy), .grant_id(grant_id)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] vec;
        logic [31:0]  rdata;
        logic         err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          gnt_q[$];
    logic [32:0] mreq_q[$];   // {write, addr}
    logic [32:0] mem_q[$];    // {err, rdata}

    int checks = 0;
    int errors = 0;

    logic mem_rdy = 1'b1, mute = 1'b0, model_rsp = 1'b0, stale = 1'b0, hs = 1'b0;
    assign mem_req_ready = mem_rdy;
    assign mem_rsp_valid = model_rsp | stale;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks accepts against expected grants and responses against the scoreboard.
    int   mon_g;
    rsp_t mon_r;
    always @(negedge clock) begin
        if (req_ready != '0) begin
            if (gnt_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_accept: got %b expected none", req_ready);
            end else begin
                mon_g = gnt_q.pop_front();
                chk("accept_onehot", 32'(req_ready), 32'(1 << mon_g));
            end
        end
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got %b expected none", rsp_valid);
            end else begin
                mon_r = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(mon_r.vec));
                chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(mon_r.err));
            end
        end
    end

    // Memory model, request side: checks each handshake against the expected request.
    logic [32:0] mreq_e;
    always @(negedge clock) begin
        if (mem_req_valid && mem_req_ready) begin
            hs = 1'b1;
            if (mreq_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_req: got addr %h expected none", mem_addr);
            end else begin
                mreq_e = mreq_q.pop_front();
                chk("mem_addr", mem_addr, mreq_e[31:0]);
                chk("mem_write", 32'(mem_write), 32'(mreq_e[32]));
            end
        end
    end

    // Memory model, response side: answers one cycle after the handshake unless muted.
    logic [32:0] mval;
    always @(posedge clock) begin
        #1;
        model_rsp = 1'b0;
        if (hs) begin
            hs = 1'b0;
            if (!mute) begin
                mval = (mem_q.size() != 0) ? mem_q.pop_front() : 33'd0;
                model_rsp     = 1'b1;
                mem_rsp_rdata = mval[31:0];
                mem_rsp_err   = mval[32];
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic expect_txn(input int g, input logic wr, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic err);
        gnt_q.push_back(g);
        mreq_q.push_back({wr, addr});
        mem_q.push_back({err, rdata});
        exp_q.push_back('{vec: N'(1 << g), rdata: rdata, err: err});
    endtask

    // Raise mask. Each requester drops after its accept unless keep is set. With keep, all drop after n_acc accepts.
    task automatic drive(input logic [N-1:0] mask, input int n_acc, input bit keep);
        int got;
        logic [N-1:0] acc;
        got = 0;
        req_valid = req_valid | mask;
        for (int c = 0; c < 300 && got < n_acc; c++) begin
            @(negedge clock);
            acc = req_ready & req_valid;
            if (acc != '0) got++;
            @(posedge clock); #1;
            if (!keep) req_valid = req_valid & ~acc;
        end
        req_valid = req_valid & ~mask;
        chk("accept_count", got, n_acc);
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) tick();
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int w;
    initial begin
        // Reset state. Requests are held high to show that no accept appears.
        req_valid = 4'b1111;
        tick(); tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        req_valid = '0;
        reset_n = 1'b1;
        tick();

        // Single read from requester 0.
        req_addr[0 +: 32] = 32'h0000_1000;
        expect_txn(0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        drive(4'b0001, 1, 1'b0);
        drain();
        chk("single_grant_id", 32'(grant_id), 0);

        // Round robin after reset: 0,1,2,3,0 with all four requesting continuously.
        do_reset();
        for (int i = 0; i < N; i++) req_addr[32*i +: 32] = 32'h2000 + 32'(16*i);
        for (int k = 0; k < 5; k++)
            expect_txn(k % N, 1'b0, 32'h2000 + 32'(16*(k % N)), 32'hA000_0000 + 32'(k), 1'b0);
        drive(4'b1111, 5, 1'b1);
        drain();

        // Memory back-pressure on a write from requester 1.
        mem_rdy = 1'b0;
        req_addr[32 +: 32]  = 32'h0000_3000;
        req_wdata[32 +: 32] = 32'hCAFE_0001;
        req_write = 4'b0010;
        expect_txn(1, 1'b1, 32'h0000_3000, 32'h0BAD_F00D, 1'b0);
        drive(4'b0010, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("stall_mem_req_valid", 32'(mem_req_valid), 1);
            chk("stall_mem_addr", mem_addr, 32'h0000_3000);
            chk("stall_mem_wdata", mem_wdata, 32'hCAFE_0001);
            chk("stall_busy", 32'(busy), 1);
        end
        tick();
        mem_rdy = 1'b1;
        drain();

        // Error on a write from requester 2. Response data then holds while idle.
        req_addr[64 +: 32] = 32'h0000_4400;
        req_write = 4'b0100;
        expect_txn(2, 1'b1, 32'h0000_4400, 32'h1234_5678, 1'b1);
        drive(4'b0100, 1, 1'b0);
        drain();
        tick(); tick();
        chk("hold_rsp_valid", 32'(rsp_valid), 0);
        chk("hold_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("hold_rsp_err", 32'(rsp_err), 1);
        req_write = '0;

        // Reset while waiting, followed by a stale memory response.
        mute = 1'b1;
        req_addr[96 +: 32] = 32'h0000_5000;
        gnt_q.push_back(3);
        mreq_q.push_back({1'b0, 32'h0000_5000});
        drive(4'b1000, 1, 1'b0);
        w = 0;
        while (!(busy && !mem_req_valid) && w < 20) begin tick(); w++; end
        chk("reached_wait", 32'(busy && !mem_req_valid), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        mute = 1'b0;
        chk("rstwait_busy", 32'(busy), 0);
        chk("rstwait_grant_id", 32'(grant_id), 0);
        stale = 1'b1;
        tick();
        stale = 1'b0;
        chk("stale_rsp_valid_a", 32'(rsp_valid), 0);
        chk("stale_busy", 32'(busy), 0);
        tick();
        chk("stale_rsp_valid_b", 32'(rsp_valid), 0);
        // The arbiter restarts from requester 0, so 1 must win over 3.
        req_addr[32 +: 32] = 32'h0000_6100;
        req_addr[96 +: 32] = 32'h0000_6300;
        expect_txn(1, 1'b0, 32'h0000_6100, 32'h0000_0061, 1'b0);
        expect_txn(3, 1'b0, 32'h0000_6300, 32'h0000_0063, 1'b0);
        drive(4'b1010, 2, 1'b0);
        drain();

`ifdef UEX_MEM_ARB_TIMEOUT_EN
        // No memory response: an error response after 16 WAIT cycles.
        mute = 1'b1;
        req_addr[0 +: 32] = 32'h0000_7000;
        gnt_q.push_back(0);
        mreq_q.push_back({1'b0, 32'h0000_7000});
        exp_q.push_back('{vec: 4'b0001, rdata: 32'h0, err: 1'b1});
        drive(4'b0001, 1, 1'b0);
        w = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (rsp_valid != '0) break;
            if (busy && !mem_req_valid) w++;
        end
        chk("timeout_wait_cycles", w, 16);
        drain();
        mute = 1'b0;
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uex_mem_arb.md
UEX_MEM_ARB -- requirements
Module: uex_mem_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 256, response-wait cycle limit (used only with UEX_MEM_ARB_TIMEOUT_EN).
REQ-003 SHALL have ports, in this order:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept strobe
- req_addr  in  N_REQ*32  per-requester address; slice i = [32*i+31:32*i]
- req_wdata  in  N_REQ*32  per-requester write data; same slicing
- req_write  in  N_REQ  1=write, 0=read
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_rdata  out  32  response read data, shared
- rsp_err  out  1  response error, shared
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request accept
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_write  out  1  memory write flag
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_rdata  in  32  memory read data
- mem_rsp_err  in  1  memory error
- busy  out  1  transaction in flight
- grant_id  out  $clog2(N_REQ)  index of current/last granted requester

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT; exactly one transaction outstanding at a time.
REQ-005 IDLE: if any req_valid, SHALL select winner round-robin, searching from (last_grant+1) mod N_REQ upward with wrap; SHALL assert req_ready[winner] for exactly that cycle, latch addr/wdata/write, set grant_id, go ISSUE.
REQ-006 req_ready SHALL be zero in all states except that IDLE accept cycle; at most one bit set.
REQ-007 ISSUE: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go WAIT next cycle.
REQ-008 WAIT: on mem_rsp_valid=1, rsp_valid[grant_id]=1 for one cycle with rsp_rdata=mem_rsp_rdata, rsp_err=mem_rsp_err (registered, one cycle after mem_rsp_valid); last_grant<=grant_id; go IDLE.
REQ-009 Minimum occupancy SHALL be 3 cycles per transaction (accept, issue, wait) plus response register; next accept no earlier than the cycle rsp_valid is asserted.
REQ-010 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-011 busy SHALL be 1 in ISSUE and WAIT, 0 in IDLE.
REQ-012 Requester dropping req_valid before accept SHALL be permitted; it is then not considered.
REQ-013 rsp_rdata/rsp_err SHALL hold their last value when rsp_valid is 0.

Reset
REQ-014 reset_n=0 on a clock edge SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req_valid=0, mem_addr=0, mem_wdata=0, mem_write=0, busy=0, grant_id=0, last_grant=N_REQ-1 (requester 0 first).
REQ-015 Reset mid-transaction SHALL abandon it silently; no rsp_valid issued.

Configuration
REQ-016 With UEX_MEM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle; reaching TIMEOUT without mem_rsp_valid SHALL produce rsp_valid[grant_id]=1, rsp_err=1, rsp_rdata=0 and return to IDLE; coincident mem_rsp_valid wins.
REQ-017 Without UEX_MEM_ARB_TIMEOUT_EN, WAIT SHALL persist indefinitely and no counter logic SHALL exist.

Verification
REQ-018 Single read: req_valid=4'b0001, addr=0x1000; memory ready immediately, rdata=0xDEADBEEF one cycle later -> rsp_valid=4'b0001, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-019 All four requesting continuously after reset -> grant order 0,1,2,3,0; each rsp_valid one-hot to matching requester.
REQ-020 mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_addr stable all 5 cycles; busy=1 throughout.
REQ-021 Reset asserted in WAIT, then stale mem_rsp_valid -> no rsp_valid, state IDLE, grant restarts at 0.
REQ-022 With UEX_MEM_ARB_TIMEOUT_EN, TIMEOUT=16, no response -> rsp_valid after 16 WAIT cycles, rsp_err=1, rsp_rdata=0.
REQ-023 mem_rsp_err=1 on a write from requester 2 -> rsp_valid=4'b0100, rsp_err=1.
